// File: rtl/bram.sv
// bram: 128 x 64-bit memory with one write port and a registered dual-word read port.
//
// Each rising clk loads data_out with {mem[idx+1], mem[idx]}. The read index idx is
// taken from the low WR_ADDR_W bits of rd_addr, and the upper word wraps modulo depth.
//
// Optional feature macro: BRAM_WRITE_FORWARD_EN
//   defined   : a half of data_out that collides with the word being written in the
//               same cycle returns data_in (write-first).
//   undefined : a colliding half returns the old memory word (read-first).
//
// Ports:
//   clk      in   1            rising-edge clock
//   rst_n    in   1            asynchronous active-low reset; clears data_out and
//                              blocks writes. Memory contents are kept.
//   we       in   1            write enable
//   wr_addr  in   WR_ADDR_W    write word address
//   rd_addr  in   RD_ADDR_W    read word address of the lower word; upper bits ignored
//   data_in  in   DATA_W       write data
//   data_out out  2*DATA_W     registered read data {word[idx+1], word[idx]}
module bram #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned WR_ADDR_W = 7,
    parameter int unsigned RD_ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [WR_ADDR_W-1:0]   wr_addr,
    input  logic [RD_ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]      data_in,
    output logic [2*DATA_W-1:0]    data_out
);

    localparam int unsigned DEPTH = 2 ** WR_ADDR_W;

    // Memory starts at zero and is never cleared by reset.
    logic [DATA_W-1:0]             r_mem [DEPTH] = '{default: '0};
    logic [2*DATA_W-1:0]           r_data_out;

    logic [WR_ADDR_W-1:0]          w_idx_lo;
    logic [WR_ADDR_W-1:0]          w_idx_hi;
    logic [DATA_W-1:0]             w_rd_lo;
    logic [DATA_W-1:0]             w_rd_hi;
    logic [RD_ADDR_W-WR_ADDR_W-1:0] w_unused_rd_hi_bits;

    assign w_idx_lo            = rd_addr[WR_ADDR_W-1:0];
    // Upper index wraps naturally at the WR_ADDR_W width (127 + 1 -> 0).
    assign w_idx_hi            = w_idx_lo + WR_ADDR_W'(1);
    assign w_unused_rd_hi_bits = rd_addr[RD_ADDR_W-1:WR_ADDR_W];

    // Read data for each half, with per-half collision handling.
    always_comb begin
        w_rd_lo = r_mem[w_idx_lo];
        w_rd_hi = r_mem[w_idx_hi];
`ifdef BRAM_WRITE_FORWARD_EN
        if (we && (wr_addr == w_idx_lo)) begin
            w_rd_lo = data_in;
        end
        if (we && (wr_addr == w_idx_hi)) begin
            w_rd_hi = data_in;
        end
`endif
    end

    // Write and read share one reset-aware process so that reset blocks writes
    // without the reset net also being used as a synchronous enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else begin
            if (we) begin
                r_mem[wr_addr] <= data_in;
            end
            r_data_out <= {w_rd_hi, w_rd_lo};
        end
    end

    assign data_out = r_data_out;

endmodule

// File: tb/tb_bram.sv
module tb_bram;

    localparam int DATA_W = 64;
    localparam int WR_W   = 7;
    localparam int RD_W   = 14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              we = 1'b0;
    logic [WR_W-1:0]   wr_addr = '0;
    logic [RD_W-1:0]   rd_addr = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [2*DATA_W-1:0] data_out;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state.
    logic [DATA_W-1:0]   m_mem [128];
    logic [2*DATA_W-1:0] m_exp = '0;

    localparam logic [63:0] VA = 64'h123456789ABCDEF0;
    localparam logic [63:0] VB = 64'hFEDCBA9876543210;
    localparam logic [63:0] VC = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] VD = 64'h5555555555555555;

    bram #(
        .DATA_W    (DATA_W),
        .WR_ADDR_W (WR_W),
        .RD_ADDR_W (RD_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Model: the word pair at rd_addr mod 128, with collisions resolved per half.
    always @(posedge clk or negedge rst_n) begin
        int lo_i;
        int hi_i;
        logic [DATA_W-1:0] lo_v;
        logic [DATA_W-1:0] hi_v;
        if (!rst_n) begin
            m_exp = '0;
        end else begin
            lo_i = int'(rd_addr) % 128;
            hi_i = (lo_i + 1) % 128;
            lo_v = m_mem[lo_i];
            hi_v = m_mem[hi_i];
`ifdef BRAM_WRITE_FORWARD_EN
            if (we && int'(wr_addr) == lo_i) lo_v = data_in;
            if (we && int'(wr_addr) == hi_i) hi_v = data_in;
`endif
            m_exp = {hi_v, lo_v};
            if (we) m_mem[int'(wr_addr)] = data_in;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (data_out !== m_exp) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, data_out, m_exp);
            end
        end
    end

    task automatic check(input string name, input logic [2*DATA_W-1:0] got,
                         input logic [2*DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, return 1 time unit after it.
    task automatic cyc(input logic w, input logic [WR_W-1:0] wa,
                       input logic [RD_W-1:0] ra, input logic [DATA_W-1:0] d);
        we      = w;
        wr_addr = wa;
        rd_addr = ra;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_fwd_lo;
        logic [DATA_W-1:0] exp_fwd_hi;
        logic [2*DATA_W-1:0] held;
        for (int i = 0; i < 128; i++) m_mem[i] = '0;
`ifdef BRAM_WRITE_FORWARD_EN
        exp_fwd_lo = 64'h2;
        exp_fwd_hi = 64'h3;
`else
        exp_fwd_lo = 64'h1;
        exp_fwd_hi = 64'h0;
`endif

        #1 rst_n = 1'b0;
        #2 check("reset_out", data_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Unwritten memory reads zero.
        cyc(1'b0, 7'd0, 14'd5, '0);
        check("unwritten_zero", data_out, '0);

        // Basic pair read.
        cyc(1'b1, 7'd10, 14'd0, VA);
        cyc(1'b1, 7'd11, 14'd0, VB);
        cyc(1'b0, 7'd0, 14'd10, '0);
        check("pair_10", data_out, 128'hFEDCBA9876543210_123456789ABCDEF0);

        // Upper rd_addr bits ignored.
        cyc(1'b0, 7'd0, 14'h3F8A, '0);
        check("upper_bits_ignored", data_out, 128'hFEDCBA9876543210_123456789ABCDEF0);

        // Output holds while rd_addr moves between edges.
        held = data_out;
        rd_addr = 14'd99;
        #2;
        check("hold_between_edges", data_out, held);

        // Wrap of upper word.
        @(posedge clk);
        #1;
        cyc(1'b1, 7'd127, 14'd0, VC);
        cyc(1'b1, 7'd0, 14'd0, VD);
        cyc(1'b0, 7'd0, 14'd127, '0);
        check("wrap_127", data_out, {VD, VC});

        // Collisions, low half then high half.
        cyc(1'b1, 7'd20, 14'd0, 64'h1);
        cyc(1'b1, 7'd20, 14'd20, 64'h2);
        check("collide_lo", data_out, {64'h0, exp_fwd_lo});
        cyc(1'b0, 7'd0, 14'd20, '0);
        check("after_collide_lo", data_out, {64'h0, 64'h2});
        cyc(1'b1, 7'd21, 14'd20, 64'h3);
        check("collide_hi", data_out, {exp_fwd_hi, 64'h2});
        cyc(1'b0, 7'd0, 14'd20, '0);
        check("after_collide_hi", data_out, {64'h3, 64'h2});

        // Async reset mid-cycle; writes blocked during reset; memory preserved.
        cyc(1'b0, 7'd0, 14'd10, '0);
        #2 rst_n = 1'b0;
        #1 check("async_reset_clear", data_out, '0);
        we      = 1'b1;
        wr_addr = 7'd10;
        data_in = 64'hDEADBEEFDEADBEEF;
        @(posedge clk);
        #1;
        check("reset_holds_zero", data_out, '0);
        @(negedge clk);
        we      = 1'b0;
        rd_addr = 14'd10;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("mem_kept_through_reset", data_out,
              128'hFEDCBA9876543210_123456789ABCDEF0);

        // Randomized traffic with biased collisions.
        for (int n = 0; n < 2000; n++) begin
            logic [RD_W-1:0] ra;
            logic [WR_W-1:0] wa;
            int sel;
            ra  = RD_W'($urandom);
            sel = int'($urandom_range(5));
            if (sel == 0) wa = ra[WR_W-1:0];
            else if (sel == 1) wa = ra[WR_W-1:0] + 7'd1;
            else wa = WR_W'($urandom);
            cyc(1'($urandom_range(1)), wa, ra, {$urandom, $urandom});
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
